vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 135 +++++++++++++
 tb/tb_vga_timing_gen.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA timing generator: free-running pixel/line counters with registered
// sync, blank and start-of-line/frame strobes, all aligned to the counts
// they are presented with.
// Optional feature macro: VGA_TIMING_GEN_FRAME_CNT_EN adds a 16-bit
// frame_cnt output that counts frame_start pulses.
module vga_timing_gen #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CNT_W    = 11
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             hblnk,
  output logic             vblnk,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SS       = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SE       = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_SS       = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SE       = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic             HS_ACT     = (HS_POL != 0) ? 1'b1 : 1'b0;
  localparam logic             VS_ACT     = (VS_POL != 0) ? 1'b1 : 1'b0;

  // Both frame totals must be representable in the counter width.
  if (H_TOTAL >= (1 << CNT_W)) begin : g_h_total_too_wide
    $error("vga_timing_gen: H_TOTAL does not fit in CNT_W bits");
  end
  if (V_TOTAL >= (1 << CNT_W)) begin : g_v_total_too_wide
    $error("vga_timing_gen: V_TOTAL does not fit in CNT_W bits");
  end

  logic [CNT_W-1:0] hcount_q, hcount_d;
  logic [CNT_W-1:0] vcount_q, vcount_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             hblnk_q, hblnk_d;
  logic             vblnk_q, vblnk_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;
  logic             h_wrap, v_wrap;

  // Next counts, with sync/blank decoded from them so the registered
  // level outputs line up with the registered counts in the same cycle.
  always_comb begin
    h_wrap   = (hcount_q == H_LAST);
    v_wrap   = (vcount_q == V_LAST);
    hcount_d = h_wrap ? '0 : hcount_q + CNT_W'(1);
    vcount_d = vcount_q;
    if (h_wrap) begin
      vcount_d = v_wrap ? '0 : vcount_q + CNT_W'(1);
    end
    hblnk_d       = (hcount_d >= H_ACT_END);
    vblnk_d       = (vcount_d >= V_ACT_END);
    hsync_d       = ((hcount_d >= H_SS) && (hcount_d < H_SE)) ? HS_ACT : ~HS_ACT;
    vsync_d       = ((vcount_d >= V_SS) && (vcount_d < V_SE)) ? VS_ACT : ~VS_ACT;
    line_start_d  = en & h_wrap;
    frame_start_d = en & h_wrap & v_wrap;
  end

  // Timing state: advances only when enabled; strobes clear when idle.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      hsync_q       <= ~HS_ACT;
      vsync_q       <= ~VS_ACT;
      hblnk_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      if (en) begin
        hcount_q <= hcount_d;
        vcount_q <= vcount_d;
        hsync_q  <= hsync_d;
        vsync_q  <= vsync_d;
        hblnk_q  <= hblnk_d;
        vblnk_q  <= vblnk_d;
      end
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign hblnk       = hblnk_q;
  assign vblnk       = vblnk_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // Frame counter steps together with the frame_start strobe it counts.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (frame_start_d) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed self-checking bench for vga_timing_gen: a default-timing
// instance for line-level behaviour, enable hold and async reset, and a
// small-timing instance for full-frame vertical behaviour.
module tb_vga_timing_gen;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Default-parameter instance
  logic        d_rst, d_en;
  logic [10:0] d_hcount, d_vcount;
  logic        d_hsync, d_vsync, d_hblnk, d_vblnk, d_ls, d_fs;

  // Small-timing instance
  logic        s_rst, s_en;
  logic [10:0] s_hcount, s_vcount;
  logic        s_hsync, s_vsync, s_hblnk, s_vblnk, s_ls, s_fs;

`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
  logic [15:0] d_frame_cnt, s_frame_cnt;
`endif

  vga_timing_gen u_dflt (
    .pclk        (pclk),
    .rst         (d_rst),
    .en          (d_en),
    .hcount      (d_hcount),
    .vcount      (d_vcount),
    .hsync       (d_hsync),
    .vsync       (d_vsync),
    .hblnk       (d_hblnk),
    .vblnk       (d_vblnk),
    .line_start  (d_ls),
    .frame_start (d_fs)
`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
    ,
    .frame_cnt   (d_frame_cnt)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE (8),
    .H_FP     (1),
    .H_SYNC   (2),
    .H_BP     (1),
    .V_ACTIVE (4),
    .V_FP     (1),
    .V_SYNC   (1),
    .V_BP     (1),
    .HS_POL   (1)
  ) u_small (
    .pclk        (pclk),
    .rst         (s_rst),
    .en          (s_en),
    .hcount      (s_hcount),
    .vcount      (s_vcount),
    .hsync       (s_hsync),
    .vsync       (s_vsync),
    .hblnk       (s_hblnk),
    .vblnk       (s_vblnk),
    .line_start  (s_ls),
    .frame_start (s_fs)
`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
    ,
    .frame_cnt   (s_frame_cnt)
`endif
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Default timing: hsync low 1048..1183, hblnk 1024..1343,
  // vsync low 771..776, vblnk 768..805.
  task automatic chk_dflt(input string tag, input int h, input int v, input int ls, input int fs);
    chk({tag, ".hcount"}, d_hcount, h);
    chk({tag, ".vcount"}, d_vcount, v);
    chk({tag, ".hsync"},  d_hsync, (h >= 1048 && h <= 1183) ? 0 : 1);
    chk({tag, ".hblnk"},  d_hblnk, (h >= 1024) ? 1 : 0);
    chk({tag, ".vsync"},  d_vsync, (v >= 771 && v <= 776) ? 0 : 1);
    chk({tag, ".vblnk"},  d_vblnk, (v >= 768) ? 1 : 0);
    chk({tag, ".line_start"},  d_ls, ls);
    chk({tag, ".frame_start"}, d_fs, fs);
  endtask

  // Small timing: H_TOTAL=12, V_TOTAL=7; hsync high 9..10, hblnk 8..11,
  // vsync low at line 5, vblnk lines 4..6.
  task automatic chk_small(input string tag, input int h, input int v, input int ls, input int fs);
    chk({tag, ".hcount"}, s_hcount, h);
    chk({tag, ".vcount"}, s_vcount, v);
    chk({tag, ".hsync"},  s_hsync, (h >= 9 && h <= 10) ? 1 : 0);
    chk({tag, ".hblnk"},  s_hblnk, (h >= 8) ? 1 : 0);
    chk({tag, ".vsync"},  s_vsync, (v == 5) ? 0 : 1);
    chk({tag, ".vblnk"},  s_vblnk, (v >= 4) ? 1 : 0);
    chk({tag, ".line_start"},  s_ls, ls);
    chk({tag, ".frame_start"}, s_fs, fs);
  endtask

  initial begin
    int fs_seen;
    int ls_seen;
    d_rst = 1'b1;
    s_rst = 1'b1;
    d_en  = 1'b0;
    s_en  = 1'b0;

    // Reset values
    @(negedge pclk);
    chk_dflt("d_reset", 0, 0, 0, 0);
    chk_small("s_reset", 0, 0, 0, 0);
`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
    chk("d_reset.frame_cnt", d_frame_cnt, 0);
    chk("s_reset.frame_cnt", s_frame_cnt, 0);
`endif

    // Reset dominates enable
    d_en = 1'b1;
    @(negedge pclk);
    chk_dflt("d_reset_en", 0, 0, 0, 0);

    // Release: first enabled edge gives hcount=1, then sweep line 0
    d_rst = 1'b0;
    for (int k = 1; k <= 1343; k++) begin
      @(negedge pclk);
      chk_dflt($sformatf("d_line0_h%0d", k), k, 0, 0, 0);
    end

    // Hold at hcount=1343 for two disabled cycles
    d_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge pclk);
      chk_dflt($sformatf("d_hold%0d", k), 1343, 0, 0, 0);
    end

    // Resume: wrap to the next line with a single line_start
    d_en = 1'b1;
    @(negedge pclk);
    chk_dflt("d_wrap", 0, 1, 1, 0);

    // Disabled right after wrap: strobe drops, counts hold at 0
    d_en = 1'b0;
    @(negedge pclk);
    chk_dflt("d_wrap_hold", 0, 1, 0, 0);

    d_en = 1'b1;
    @(negedge pclk);
    chk_dflt("d_resume", 1, 1, 0, 0);

    // Advance into horizontal sync on line 1
    repeat (1099) @(negedge pclk);
    chk_dflt("d_pre_rst", 1100, 1, 0, 0);

    // Asynchronous reset mid-line, observed before the next pclk edge
    #2;
    d_rst = 1'b1;
    #1;
    chk_dflt("d_async_rst", 0, 0, 0, 0);
    @(negedge pclk);
    chk_dflt("d_async_rst_held", 0, 0, 0, 0);
    d_rst = 1'b0;
    @(negedge pclk);
    chk_dflt("d_after_rst", 1, 0, 0, 0);
    d_en = 1'b0;
`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
    chk("d_frame_cnt", d_frame_cnt, 0);
`endif

    // Small timing: three complete frames
    s_rst   = 1'b0;
    s_en    = 1'b1;
    fs_seen = 0;
    ls_seen = 0;
    for (int k = 1; k <= 3 * 12 * 7; k++) begin
      int h;
      int v;
      @(negedge pclk);
      h = k % 12;
      v = (k / 12) % 7;
      chk_small($sformatf("s_k%0d", k), h, v, (h == 0) ? 1 : 0, (h == 0 && v == 0) ? 1 : 0);
      if (s_fs === 1'b1) fs_seen++;
      if (s_ls === 1'b1) ls_seen++;
    end
    chk("s_frame_start_count", fs_seen, 3);
    chk("s_line_start_count", ls_seen, 21);
`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
    chk("s_frame_cnt", s_frame_cnt, 3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
